// File: rtl/pma_rule_table_if.sv
// -----------------------------------------------------------------------------
// pma_rule_table_if
//   Bundles the write port and the lookup port of the PMA rule table.
//   master : the requester (software/debug writer, core lookup units)
//   slave  : the rule table itself
//
//   Signals
//     wr_valid   master->slave  write request valid
//     wr_ready   slave->master  write accepted when wr_valid & wr_ready
//     wr_idx     master->slave  target entry
//     wr_field   master->slave  0=shadow base, 1=shadow len, 2=shadow attr,
//                               3=commit shadow->active
//     wr_data    master->slave  write data (attr uses [7:0])
//     wr_err     slave->master  one-cycle pulse: request rejected
//     req_valid  master->slave  lookup valid (always accepted)
//     req_addr   master->slave  lookup address
//     resp_valid slave->master  lookup result valid
//     resp_attr  slave->master  {shared, cached, execute, nonidempotent}
//     resp_hit   slave->master  at least one active entry matched
// -----------------------------------------------------------------------------
interface pma_rule_table_if #(
  parameter int unsigned IdxWidth = 4
);
  logic                wr_valid;
  logic                wr_ready;
  logic [IdxWidth-1:0] wr_idx;
  logic [1:0]          wr_field;
  logic [63:0]         wr_data;
  logic                wr_err;
  logic                req_valid;
  logic [63:0]         req_addr;
  logic                resp_valid;
  logic [3:0]          resp_attr;
  logic                resp_hit;

  modport master (
    output wr_valid, wr_idx, wr_field, wr_data, req_valid, req_addr,
    input  wr_ready, wr_err, resp_valid, resp_attr, resp_hit
  );

  modport slave (
    input  wr_valid, wr_idx, wr_field, wr_data, req_valid, req_addr,
    output wr_ready, wr_err, resp_valid, resp_attr, resp_hit
  );
endinterface

// File: rtl/pma_rule_table.sv
// -----------------------------------------------------------------------------
// pma_rule_table
//   Run-time programmable PMA rule table. Each entry holds a shadow and an
//   active copy of base/len/attr. Writers fill the shadow copy field by field
//   and then commit it to the active copy in one atomic step. Lookups compare
//   an address against every active entry and return the OR of the matching
//   attributes one cycle later, one result per cycle.
//
//   Parameters
//     NrRules  number of table entries
//
//   Ports
//     clk_i   clock
//     rst_ni  asynchronous reset, active-low
//     bus     pma_rule_table_if.slave (write port + lookup port)
//
//   Optional feature (compile-time macro PMA_LOCK_EN)
//     defined   : active attr[7]=1 locks the entry until reset; any write to
//                 a locked index is rejected with a wr_err pulse.
//     undefined : attr[7] is dropped on write; locks do not exist.
// -----------------------------------------------------------------------------
module pma_rule_table #(
  parameter int unsigned NrRules = 16
) (
  input logic             clk_i,
  input logic             rst_ni,
  pma_rule_table_if.slave bus
);

  localparam int unsigned IdxWidth = (NrRules > 1) ? $clog2(NrRules) : 1;

  typedef enum logic {
    Idle,
    Commit
  } state_e;

  state_e              state_q;
  logic [IdxWidth-1:0] commitIdx_q;
  logic                wrReady_q;
  logic                wrErr_q;

  logic [63:0] shadowBase_q [NrRules];
  logic [63:0] shadowLen_q  [NrRules];
  logic [3:0]  shadowAttr_q [NrRules];
  logic [63:0] activeBase_q [NrRules];
  logic [63:0] activeLen_q  [NrRules];
  logic [3:0]  activeAttr_q [NrRules];
`ifdef PMA_LOCK_EN
  logic        shadowLock_q [NrRules];
  logic        activeLock_q [NrRules];
`endif

  logic        respValid_q;
  logic        respHit_q;
  logic [3:0]  respAttr_q;
  logic        respHit_d;
  logic [3:0]  respAttr_d;

  logic        idxInRange;
  logic        wrLocked;
  logic        wrAccept;
  logic        wrReject;

  // Out-of-range indices must never touch the arrays; the lock lookup is
  // therefore gated by the range check.
  assign idxInRange = 32'(bus.wr_idx) < NrRules;
`ifdef PMA_LOCK_EN
  assign wrLocked   = idxInRange && activeLock_q[bus.wr_idx];
`else
  assign wrLocked   = 1'b0;
`endif
  // wrReady_q is high exactly when the FSM is idle.
  assign wrAccept   = bus.wr_valid && wrReady_q;
  assign wrReject   = !idxInRange || wrLocked;

  // Write FSM: shadow field updates in Idle, one-cycle atomic shadow->active
  // copy in Commit. Reset clears both copies, which also aborts a pending copy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= Idle;
      commitIdx_q <= '0;
      wrReady_q   <= 1'b1;
      wrErr_q     <= 1'b0;
      for (int i = 0; i < int'(NrRules); i++) begin
        shadowBase_q[i] <= '0;
        shadowLen_q[i]  <= '0;
        shadowAttr_q[i] <= '0;
        activeBase_q[i] <= '0;
        activeLen_q[i]  <= '0;
        activeAttr_q[i] <= '0;
`ifdef PMA_LOCK_EN
        shadowLock_q[i] <= 1'b0;
        activeLock_q[i] <= 1'b0;
`endif
      end
    end else begin
      wrErr_q <= 1'b0;
      case (state_q)
        Idle: begin
          if (wrAccept) begin
            if (wrReject) begin
              wrErr_q <= 1'b1;
            end else begin
              case (bus.wr_field)
                2'd0: shadowBase_q[bus.wr_idx] <= bus.wr_data;
                2'd1: shadowLen_q[bus.wr_idx]  <= bus.wr_data;
                2'd2: begin
                  shadowAttr_q[bus.wr_idx] <= bus.wr_data[3:0];
`ifdef PMA_LOCK_EN
                  shadowLock_q[bus.wr_idx] <= bus.wr_data[7];
`endif
                end
                default: begin
                  commitIdx_q <= bus.wr_idx;
                  state_q     <= Commit;
                  wrReady_q   <= 1'b0;
                end
              endcase
            end
          end
        end
        Commit: begin
          activeBase_q[commitIdx_q] <= shadowBase_q[commitIdx_q];
          activeLen_q[commitIdx_q]  <= shadowLen_q[commitIdx_q];
          activeAttr_q[commitIdx_q] <= shadowAttr_q[commitIdx_q];
`ifdef PMA_LOCK_EN
          activeLock_q[commitIdx_q] <= shadowLock_q[commitIdx_q];
`endif
          state_q   <= Idle;
          wrReady_q <= 1'b1;
        end
        default: begin
          state_q   <= Idle;
          wrReady_q <= 1'b1;
        end
      endcase
    end
  end

  // Range match against the active table. The upper bound is computed in 65
  // bits so an entry reaching the top of memory cannot wrap onto low
  // addresses; len=0 yields an empty range and never matches.
  always_comb begin
    respHit_d  = 1'b0;
    respAttr_d = '0;
    for (int i = 0; i < int'(NrRules); i++) begin
      if ((bus.req_addr >= activeBase_q[i]) &&
          ({1'b0, bus.req_addr} < ({1'b0, activeBase_q[i]} + {1'b0, activeLen_q[i]}))) begin
        respHit_d  = 1'b1;
        respAttr_d = respAttr_d | activeAttr_q[i];
      end
    end
  end

  // Lookup pipeline register: one result per cycle, attr/hit hold their last
  // value while no lookup is issued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      respValid_q <= 1'b0;
      respHit_q   <= 1'b0;
      respAttr_q  <= '0;
    end else begin
      respValid_q <= bus.req_valid;
      if (bus.req_valid) begin
        respHit_q  <= respHit_d;
        respAttr_q <= respAttr_d;
      end
    end
  end

  assign bus.wr_ready   = wrReady_q;
  assign bus.wr_err     = wrErr_q;
  assign bus.resp_valid = respValid_q;
  assign bus.resp_hit   = respHit_q;
  assign bus.resp_attr  = respAttr_q;

endmodule

// File: tb/tb_pma_rule_table.sv
// -----------------------------------------------------------------------------
// tb_pma_rule_table
//   Directed bench for pma_rule_table built with NrRules=12 so that index 12
//   is representable and out of range. Lookups push their expected response
//   into a queue; an independent monitor pops and compares each response.
//   Expectations for the lock case follow PMA_LOCK_EN.
// -----------------------------------------------------------------------------
module tb_pma_rule_table;

  localparam int unsigned NrRules  = 12;
  localparam int unsigned IdxWidth = 4;

  typedef struct {
    logic        hit;
    logic [3:0]  attr;
    int unsigned cycle;
    string       name;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  int          compared = 0;
  int          mismatched = 0;
  int unsigned cycleCnt = 0;
  exp_t        expQ[$];
  exp_t        monEntry;
  logic        lockEn;

  pma_rule_table_if #(.IdxWidth(IdxWidth)) bus ();

  pma_rule_table #(.NrRules(NrRules)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  // Free-running clock and cycle counter used to check lookup latency.
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycleCnt <= cycleCnt + 1;

  // Shared comparator for both the driver and the monitor.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Issues one write; waits (bounded) for ready, then checks the error pulse
  // visible in the cycle after acceptance.
  task automatic applyWrite(input logic [IdxWidth-1:0] idx, input logic [1:0] field,
                            input logic [63:0] data, input logic expErr, input string name);
    for (int k = 0; k < 8 && !bus.wr_ready; k++) step();
    if (!bus.wr_ready) checkOutput({name, " ready timeout"}, 64'(bus.wr_ready), 64'd1);
    bus.wr_valid = 1'b1;
    bus.wr_idx   = idx;
    bus.wr_field = field;
    bus.wr_data  = data;
    step();
    bus.wr_valid = 1'b0;
    checkOutput({name, " err"}, 64'(bus.wr_err), 64'(expErr));
  endtask

  // Commit helper: returns inside the COMMIT cycle when the commit was taken.
  task automatic commitEntry(input logic [IdxWidth-1:0] idx, input logic expErr, input string name);
    applyWrite(idx, 2'd3, 64'd0, expErr, name);
    checkOutput({name, " ready"}, 64'(bus.wr_ready), expErr ? 64'd1 : 64'd0);
  endtask

  task automatic applyLookup(input logic [63:0] addr, input logic hit, input logic [3:0] attr,
                             input string name);
    exp_t e;
    e.hit   = hit;
    e.attr  = attr;
    e.cycle = cycleCnt + 1;
    e.name  = name;
    expQ.push_back(e);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    step();
    bus.req_valid = 1'b0;
  endtask

  // Monitor: every presented response is matched against the oldest
  // outstanding expectation, including its arrival cycle.
  always @(negedge clk_i) begin
    if (rst_ni && bus.resp_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected resp_valid", 64'd1, 64'd0);
      end else begin
        monEntry = expQ.pop_front();
        checkOutput({monEntry.name, " hit"}, 64'(bus.resp_hit), 64'(monEntry.hit));
        checkOutput({monEntry.name, " attr"}, 64'(bus.resp_attr), 64'(monEntry.attr));
        checkOutput({monEntry.name, " latency"}, 64'(cycleCnt), 64'(monEntry.cycle));
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed stimulus sequence.
  initial begin
`ifdef PMA_LOCK_EN
    lockEn = 1'b1;
`else
    lockEn = 1'b0;
`endif
    rst_ni        = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_idx    = '0;
    bus.wr_field  = '0;
    bus.wr_data   = '0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;

    // T1: reset values, then an empty-table lookup.
    repeat (2) @(negedge clk_i);
    checkOutput("reset wr_ready", 64'(bus.wr_ready), 64'd1);
    checkOutput("reset wr_err", 64'(bus.wr_err), 64'd0);
    checkOutput("reset resp_valid", 64'(bus.resp_valid), 64'd0);
    checkOutput("reset resp_attr", 64'(bus.resp_attr), 64'd0);
    checkOutput("reset resp_hit", 64'(bus.resp_hit), 64'd0);
    step();
    rst_ni = 1'b1;
    applyLookup(64'h8000_0000, 1'b0, 4'h0, "T1 empty");

    // T2: single region, both boundaries.
    applyWrite(4'd0, 2'd0, 64'h8000_0000, 1'b0, "T2 base");
    applyWrite(4'd0, 2'd1, 64'h1000, 1'b0, "T2 len");
    applyWrite(4'd0, 2'd2, 64'h6, 1'b0, "T2 attr");
    commitEntry(4'd0, 1'b0, "T2 commit");
    applyLookup(64'h8000_0FFF, 1'b0, 4'h0, "T2 commit-cycle old");
    applyLookup(64'h8000_0FFF, 1'b1, 4'h6, "T2 last byte");
    applyLookup(64'h8000_0000, 1'b1, 4'h6, "T2 base byte");
    applyLookup(64'h8000_1000, 1'b0, 4'h0, "T2 end excl");
    applyLookup(64'h7FFF_FFFF, 1'b0, 4'h0, "T2 below");

    // T3: entry at the top of memory must not wrap to zero.
    applyWrite(4'd1, 2'd0, 64'hFFFF_FFFF_FFFF_F000, 1'b0, "T3 base");
    applyWrite(4'd1, 2'd1, 64'h2000, 1'b0, "T3 len");
    applyWrite(4'd1, 2'd2, 64'h1, 1'b0, "T3 attr");
    commitEntry(4'd1, 1'b0, "T3 commit");
    step();
    applyLookup(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'h1, "T3 top");
    applyLookup(64'h0, 1'b0, 4'h0, "T3 no wrap");
    applyLookup(64'hFFFF_FFFF_FFFF_EFFF, 1'b0, 4'h0, "T3 below");

    // T4: overlapping entries OR their attributes; commit-cycle visibility.
    applyWrite(4'd2, 2'd0, 64'h8000_0000, 1'b0, "T4 base");
    applyWrite(4'd2, 2'd1, 64'h1000, 1'b0, "T4 len");
    applyWrite(4'd2, 2'd2, 64'h9, 1'b0, "T4 attr");
    commitEntry(4'd2, 1'b0, "T4 commit");
    applyLookup(64'h8000_0800, 1'b1, 4'h6, "T4 commit-cycle");
    applyLookup(64'h8000_0800, 1'b1, 4'hF, "T4 after commit");
    step();
    checkOutput("T4 idle resp_valid", 64'(bus.resp_valid), 64'd0);
    checkOutput("T4 hold attr", 64'(bus.resp_attr), 64'hF);
    checkOutput("T4 hold hit", 64'(bus.resp_hit), 64'd1);

    // Shadow writes alone never change lookups.
    applyWrite(4'd0, 2'd2, 64'h1, 1'b0, "shadow attr");
    applyLookup(64'h8000_0800, 1'b1, 4'hF, "shadow isolated");
    applyWrite(4'd0, 2'd2, 64'h6, 1'b0, "shadow restore");

    // T5: out-of-range index is rejected without any state change.
    applyWrite(4'd12, 2'd0, 64'h0, 1'b1, "T5 base");
    checkOutput("T5 ready", 64'(bus.wr_ready), 64'd1);
    step();
    checkOutput("T5 err pulse end", 64'(bus.wr_err), 64'd0);
    commitEntry(4'd12, 1'b1, "T5 commit");
    applyLookup(64'h8000_0800, 1'b1, 4'hF, "T5 unchanged");

    // T6: locked entry (only when the lock feature is built in).
    applyWrite(4'd3, 2'd0, 64'h1000_0000, 1'b0, "T6 base");
    applyWrite(4'd3, 2'd1, 64'h100, 1'b0, "T6 len");
    applyWrite(4'd3, 2'd2, 64'h81, 1'b0, "T6 attr");
    commitEntry(4'd3, 1'b0, "T6 commit");
    step();
    applyLookup(64'h1000_0010, 1'b1, 4'h1, "T6 initial");
    applyWrite(4'd3, 2'd0, 64'h0, lockEn, "T6 rewrite base");
    commitEntry(4'd3, lockEn, "T6 recommit");
    step();
    applyLookup(64'h1000_0010, lockEn, lockEn ? 4'h1 : 4'h0, "T6 old range");
    applyLookup(64'h10, !lockEn, lockEn ? 4'h0 : 4'h1, "T6 new range");

    // Reset during COMMIT aborts the copy and clears the table.
    applyWrite(4'd4, 2'd0, 64'h2000_0000, 1'b0, "RST base");
    applyWrite(4'd4, 2'd1, 64'h10, 1'b0, "RST len");
    applyWrite(4'd4, 2'd2, 64'h4, 1'b0, "RST attr");
    commitEntry(4'd4, 1'b0, "RST commit");
    rst_ni = 1'b0;
    step();
    checkOutput("RST wr_ready", 64'(bus.wr_ready), 64'd1);
    checkOutput("RST resp_valid", 64'(bus.resp_valid), 64'd0);
    checkOutput("RST resp_attr", 64'(bus.resp_attr), 64'd0);
    rst_ni = 1'b1;
    applyLookup(64'h2000_0000, 1'b0, 4'h0, "RST aborted entry");
    applyLookup(64'h8000_0800, 1'b0, 4'h0, "RST cleared table");

    repeat (3) step();
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
